// File: rtl/sel_4_1_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing a 2-bit 4:1 selector path.
// The grant and selector code are registered; the data mux reads the registered SEL.
module sel_4_1_rr_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 4
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [3:0] REQ,
   input  logic [1:0] A,
   input  logic [1:0] B,
   input  logic [1:0] C,
   input  logic [1:0] D,
   output logic [3:0] GNT,
   output logic [1:0] SEL,
   output logic [1:0] OUT,
   output logic       OUT_VALID
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       sel_q, sel_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Returns {found, index}; index is the first set request at or after ptr.
   function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (req[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   function automatic logic [3:0] one_hot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   // State register
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         ptr_q   <= 2'd0;
         sel_q   <= 2'd0;
         gnt_q   <= 4'b0000;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: arbitration from IDLE, hold or release-and-rearbitrate in GRANT
   always_comb begin
      logic [2:0] pick_idle;
      logic [2:0] pick_rel;
      logic       release_grant;
      state_d       = state_q;
      ptr_d         = ptr_q;
      sel_d         = sel_q;
      gnt_d         = gnt_q;
      cnt_d         = cnt_q;
      pick_idle     = rr_pick(REQ, ptr_q);
      pick_rel      = rr_pick(REQ, sel_q + 2'd1);
      release_grant = !REQ[sel_q] || (cnt_q == CNT_W'(MAX_HOLD - 1));
      case (state_q)
         ST_IDLE: begin
            if (pick_idle[2]) begin
               state_d = ST_GRANT;
               sel_d   = pick_idle[1:0];
               gnt_d   = one_hot(pick_idle[1:0]);
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (release_grant) begin
               // The releasing requester becomes lowest priority, so a lone requester still wins again.
               ptr_d = sel_q + 2'd1;
               if (pick_rel[2]) begin
                  sel_d = pick_rel[1:0];
                  gnt_d = one_hot(pick_rel[1:0]);
                  cnt_d = '0;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = 4'b0000;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
         end
      endcase
   end

   // Outputs: registered grant/select, data mux gated by valid
   always_comb begin
      GNT       = gnt_q;
      SEL       = sel_q;
      OUT_VALID = (state_q == ST_GRANT);
      OUT       = 2'b00;
      if (state_q == ST_GRANT) begin
         case (sel_q)
            2'd0:    OUT = A;
            2'd1:    OUT = B;
            2'd2:    OUT = C;
            2'd3:    OUT = D;
            default: OUT = 2'b00;
         endcase
      end else begin
         OUT = 2'b00;
      end
   end

endmodule

// File: doc/sel_4_1_rr_arbiter.md
Name: sel_4_1_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4-to-1 2-bit selector path.
- Four requesters each present 2-bit data on A/B/C/D and raise a REQ bit.
- The block grants one requester at a time, drives the selector SEL code from a registered grant, and forwards the selected data with a valid flag.
- A hold limit bounds how long any one requester can keep the path, which guarantees fairness.

Parameters:
- MAX_HOLD, 4, maximum consecutive grant cycles per requester per grant; legal range 1..15.
- CNT_W, 4, width of the hold counter; must hold MAX_HOLD-1.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  synchronous, active-low reset; sampled on the CLK rising edge.
- REQ  input  4  request per source; bit0=A, bit1=B, bit2=C, bit3=D.
- A  input  2  source 0 data.
- B  input  2  source 1 data.
- C  input  2  source 2 data.
- D  input  2  source 3 data.
- GNT  output  4  one-hot registered grant; all zeros when idle.
- SEL  output  2  registered selector code of the current or last grant (00=A, 01=B, 10=C, 11=D).
- OUT  output  2  selected data; combinational from SEL and A..D, forced to 00 when OUT_VALID=0.
- OUT_VALID  output  1  high while a grant is active.

Behaviour:
- Reset:
  - When RST_N=0 at a rising edge: GNT=0000, SEL=00, OUT_VALID=0, OUT=00, PTR=0, CNT=0, state=IDLE.
  - Reset overrides everything, including mid-grant. No transfer completes in the reset cycle.
- Internal state:
  - state in {IDLE, GRANT}.
  - PTR (2 bits) is the highest-priority index for the next arbitration.
  - CNT (CNT_W bits) counts grant cycles.
- Arbitration function:
  - Search REQ starting at PTR, in the order PTR, PTR+1, PTR+2, PTR+3 (mod 4).
  - The first set bit wins.
- IDLE:
  - If REQ != 0 at the edge: go to GRANT, SEL = winner, GNT = one-hot(winner), CNT = 0.
  - Else remain in IDLE.
  - Latency from REQ rising to GNT rising is exactly 1 cycle.
- GRANT:
  - OUT_VALID=1 and OUT = data of source SEL.
  - A transfer occurs in every cycle where GNT[i]=1 and REQ[i]=1.
  - At each edge, release if REQ[SEL]=0 or CNT == MAX_HOLD-1; otherwise CNT += 1 and the grant is held.
- On release:
  - PTR = SEL+1 (mod 4).
  - Re-arbitrate in the same edge using the new PTR and the current REQ.
  - If there is a winner: GNT/SEL switch to it directly with no idle bubble, and CNT=0.
  - If there is no winner: go to IDLE, GNT=0000, OUT_VALID=0, SEL holds its last value.
- Boundary conditions:
  - A lone requester that hits MAX_HOLD is re-granted immediately: GNT stays high, CNT returns to 0. It wins because it is the last in search order.
  - A requester that drops REQ still sees GNT high for that one cycle. No transfer is counted, because REQ=0 in that cycle.
  - REQ changes on non-granted bits have no effect until the next arbitration.
  - Simultaneous release and new requests: the new requests take part in the same-edge arbitration.
  - MAX_HOLD=1: every grant lasts exactly 1 cycle, giving a strict rotation among active requesters.
  - GNT is always one-hot or zero, and GNT[SEL]=1 whenever OUT_VALID=1.
- Data path:
  - Pure 4:1 2-bit select; no arithmetic.
  - OUT must equal the selector truth table for the registered SEL.

Test Plan:
- Reset: hold RST_N=0 for 2 cycles with REQ=1111 -> GNT=0000, SEL=00, OUT_VALID=0, OUT=00. After release, the next edge gives GNT=0001, SEL=00.
- Single requester hold, MAX_HOLD=4: REQ=0100 for 10 cycles with C=10 -> GNT=0100 continuously from cycle 1, OUT=10, OUT_VALID=1. CNT sequence is 0,1,2,3,0,1...
- Round-robin fairness, MAX_HOLD=2: REQ=1111 steady, A..D = 00,01,10,11 -> the grant sequence is A,A,B,B,C,C,D,D,A,... with no idle cycles. OUT follows 00,00,01,01,10,10,11,11.
- Early release: B granted, REQ[1] drops in its second grant cycle while REQ=1000 -> GNT=0010 in that cycle, then GNT=1000, SEL=11 on the next edge.
- All requests drop: the granted requester drops with REQ=0000 -> after that cycle, GNT=0000, OUT_VALID=0, OUT=00, SEL holds. A later REQ=0001 wins from PTR=SEL+1.
- Reset mid-grant: RST_N=0 while GNT=0010 with CNT=1 -> the next edge gives GNT=0000, PTR=0. After reset, REQ=0011 grants A first.
